// File: rtl/fetch_ifid.sv
`default_nettype none
// ============================================================================
// fetch_ifid : PC/instruction-fetch stage with skid buffer and IF/ID register
// Rev 1.0
// ============================================================================
module fetch_ifid #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        En,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  input  logic        Halt,
  output logic [15:0] IMemAddr,
  output logic        IMemRd,
  input  logic [15:0] IMemData,
  input  logic        IMemDone,
  input  logic        IMemStall,
  output logic [15:0] DecInstruct,
  output logic [15:0] DecPCInc,
  output logic        DecValid
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        armed_q;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pc_inc;
  logic [15:0] dec_instr_q, dec_instr_d;
  logic [15:0] dec_pcinc_q, dec_pcinc_d;
  logic        dec_valid_q, dec_valid_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pcinc_q, skid_pcinc_d;
  logic        fetch_done;
  logic        pending;

  assign pc_inc     = pc_q + 16'd2;
  // armed_q keeps the first post-reset cycle request-free, so a stale done is ignored
  assign fetch_done = (state_q == S_FETCH) && armed_q && IMemDone;
  assign pending    = IMemStall && !IMemDone;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (Redirect) begin
      state_d = pending ? S_DRAIN : S_FETCH;
    end else if (Halt) begin
      state_d = S_HALTED;
    end else begin
      case (state_q)
        S_FETCH:  if (fetch_done && !En) state_d = S_HOLD;
        S_HOLD:   if (En) state_d = S_FETCH;
        S_DRAIN:  if (IMemDone) state_d = S_FETCH;
        S_HALTED: state_d = S_HALTED;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    IMemRd   = (state_q == S_FETCH) && armed_q;
    IMemAddr = pc_q;
  end

  always_comb begin
    pc_d         = pc_q;
    dec_instr_d  = dec_instr_q;
    dec_pcinc_d  = dec_pcinc_q;
    dec_valid_d  = dec_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pcinc_d = skid_pcinc_q;
    if (Redirect) begin
      pc_d         = RedirectPC;
      dec_instr_d  = NOP_INSTR;
      dec_valid_d  = 1'b0;
      skid_instr_d = NOP_INSTR;
      skid_pcinc_d = RESET_PC;
    end else if (Halt) begin
      skid_instr_d = NOP_INSTR;
      skid_pcinc_d = RESET_PC;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (fetch_done) begin
            pc_d = pc_inc;
            if (En) begin
              dec_instr_d = IMemData;
              dec_pcinc_d = pc_inc;
              dec_valid_d = 1'b1;
            end else begin
              skid_instr_d = IMemData;
              skid_pcinc_d = pc_inc;
            end
          end else if (En) begin
            dec_instr_d = NOP_INSTR;
            dec_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (En) begin
            dec_instr_d  = skid_instr_q;
            dec_pcinc_d  = skid_pcinc_q;
            dec_valid_d  = 1'b1;
            skid_instr_d = NOP_INSTR;
            skid_pcinc_d = RESET_PC;
          end
        end
        S_DRAIN: begin
          if (En) begin
            dec_instr_d = NOP_INSTR;
            dec_valid_d = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q      <= 1'b0;
      pc_q         <= RESET_PC;
      dec_instr_q  <= NOP_INSTR;
      dec_pcinc_q  <= RESET_PC;
      dec_valid_q  <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pcinc_q <= RESET_PC;
    end else begin
      armed_q      <= 1'b1;
      pc_q         <= pc_d;
      dec_instr_q  <= dec_instr_d;
      dec_pcinc_q  <= dec_pcinc_d;
      dec_valid_q  <= dec_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pcinc_q <= skid_pcinc_d;
    end
  end

  assign DecInstruct = dec_instr_q;
  assign DecPCInc    = dec_pcinc_q;
  assign DecValid    = dec_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ifid.sv
`default_nettype none
// ============================================================================
// tb_fetch_ifid : directed + randomized bench with a behavioural fetch model
// Rev 1.0
// ============================================================================
module tb_fetch_ifid;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP      = 16'h0800;
  localparam int M_FETCH  = 0;
  localparam int M_HOLD   = 1;
  localparam int M_DRAIN  = 2;
  localparam int M_HALTED = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        En = 1'b0;
  logic        Redirect = 1'b0;
  logic [15:0] RedirectPC = 16'h0000;
  logic        Halt = 1'b0;
  logic [15:0] IMemAddr;
  logic        IMemRd;
  logic [15:0] IMemData = 16'h0000;
  logic        IMemDone = 1'b0;
  logic        IMemStall = 1'b0;
  logic [15:0] DecInstruct;
  logic [15:0] DecPCInc;
  logic        DecValid;

  fetch_ifid #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .En(En), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .Halt(Halt), .IMemAddr(IMemAddr), .IMemRd(IMemRd), .IMemData(IMemData),
    .IMemDone(IMemDone), .IMemStall(IMemStall), .DecInstruct(DecInstruct),
    .DecPCInc(DecPCInc), .DecValid(DecValid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: fetch mode, PC, IF/ID contents and skid buffer
  int          m_mode;
  bit          m_armed;
  logic [15:0] m_pc, m_instr, m_pcinc, m_skid_instr, m_skid_pcinc;
  bit          m_valid;

  task automatic model_reset();
    m_mode = M_FETCH; m_armed = 1'b0; m_pc = RESET_PC;
    m_instr = NOP; m_pcinc = RESET_PC; m_valid = 1'b0;
    m_skid_instr = NOP; m_skid_pcinc = RESET_PC;
  endtask

  task automatic model_step();
    bit got;
    got = (m_mode == M_FETCH) && m_armed && IMemDone;
    if (Redirect) begin
      m_pc = RedirectPC; m_instr = NOP; m_valid = 1'b0;
      m_mode = (IMemStall && !IMemDone) ? M_DRAIN : M_FETCH;
    end else if (Halt) begin
      m_mode = M_HALTED;
    end else if (m_mode == M_FETCH) begin
      if (got) begin
        if (En) begin
          m_instr = IMemData; m_pcinc = m_pc + 16'd2; m_valid = 1'b1;
        end else begin
          m_skid_instr = IMemData; m_skid_pcinc = m_pc + 16'd2; m_mode = M_HOLD;
        end
        m_pc = m_pc + 16'd2;
      end else if (En) begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end else if (m_mode == M_HOLD) begin
      if (En) begin
        m_instr = m_skid_instr; m_pcinc = m_skid_pcinc; m_valid = 1'b1; m_mode = M_FETCH;
      end
    end else if (m_mode == M_DRAIN) begin
      if (En) begin
        m_instr = NOP; m_valid = 1'b0;
      end
      if (IMemDone) m_mode = M_FETCH;
    end
    m_armed = 1'b1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check1("m_IMemRd", IMemRd, (m_mode == M_FETCH) && m_armed);
      check16("m_IMemAddr", IMemAddr, m_pc);
      check1("m_DecValid", DecValid, m_valid);
      check16("m_DecInstruct", DecInstruct, m_instr);
      if (m_valid) check16("m_DecPCInc", DecPCInc, m_pcinc);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic mem_hit(input logic [15:0] base);
    IMemDone  = IMemRd;
    IMemStall = 1'b0;
    IMemData  = base + (IMemAddr >> 1);
  endtask

  initial begin
    repeat (3) step();
    check1("rst_rd", IMemRd, 1'b0);
    check16("rst_instr", DecInstruct, 16'h0800);
    check16("rst_pcinc", DecPCInc, 16'h0000);
    check1("rst_valid", DecValid, 1'b0);
    check16("rst_addr", IMemAddr, 16'h0000);

    // Back-to-back hits
    rst = 1'b0; En = 1'b1; mem_hit(16'hC001);
    step(); check16("hit_addr0", IMemAddr, 16'h0000); check1("hit_rd0", IMemRd, 1'b1);
    mem_hit(16'hC001);
    step(); check16("hit_instr1", DecInstruct, 16'hC001); check16("hit_pcinc1", DecPCInc, 16'h0002);
    check1("hit_valid1", DecValid, 1'b1); check16("hit_addr2", IMemAddr, 16'h0002);
    mem_hit(16'hC001);
    step(); check16("hit_instr2", DecInstruct, 16'hC002); check16("hit_pcinc2", DecPCInc, 16'h0004);
    check16("hit_addr4", IMemAddr, 16'h0004);

    // Decode stalls while a fetch returns: skid buffer
    En = 1'b0; IMemDone = 1'b1; IMemData = 16'hA5A5;
    step(); check1("hold_rd", IMemRd, 1'b0); check16("hold_instr", DecInstruct, 16'hC002);
    IMemDone = 1'b0;
    step(); check16("hold_instr2", DecInstruct, 16'hC002);
    step(); check16("hold_pcinc", DecPCInc, 16'h0004); check1("hold_rd2", IMemRd, 1'b0);
    En = 1'b1;
    step(); check16("skid_instr", DecInstruct, 16'hA5A5); check16("skid_pcinc", DecPCInc, 16'h0006);
    check16("skid_addr", IMemAddr, 16'h0006); check1("skid_rd", IMemRd, 1'b1);

    // Redirect with a request outstanding
    IMemDone = 1'b0; IMemStall = 1'b1;
    step(); check1("stall_bubble", DecValid, 1'b0);
    Redirect = 1'b1; RedirectPC = 16'h0100;
    step(); check1("rd_drain_valid", DecValid, 1'b0); check1("rd_drain_rd", IMemRd, 1'b0);
    check16("rd_drain_addr", IMemAddr, 16'h0100);
    Redirect = 1'b0; IMemDone = 1'b1; IMemData = 16'hDEAD; IMemStall = 1'b0;
    step(); check1("drop_valid", DecValid, 1'b0); check1("drop_rd", IMemRd, 1'b1);
    check16("drop_addr", IMemAddr, 16'h0100);
    mem_hit(16'hC001);
    step(); check16("rd_instr", DecInstruct, 16'hC081); check16("rd_pcinc", DecPCInc, 16'h0102);

    // Redirect + En=0 + done in the same cycle
    Redirect = 1'b1; RedirectPC = 16'h0040; En = 1'b0; IMemDone = 1'b1; IMemData = 16'hBEEF;
    step(); check16("flush_instr", DecInstruct, 16'h0800); check1("flush_valid", DecValid, 1'b0);
    check16("flush_addr", IMemAddr, 16'h0040); check1("flush_rd", IMemRd, 1'b1);

    // Halt at PC 8, resume by redirect
    RedirectPC = 16'h0008; En = 1'b1; IMemDone = 1'b0;
    step(); check16("pre_halt_addr", IMemAddr, 16'h0008);
    Redirect = 1'b0; Halt = 1'b1; mem_hit(16'hC001);
    step(); check1("halt_rd", IMemRd, 1'b0); check16("halt_addr", IMemAddr, 16'h0008);
    IMemDone = 1'b0;
    step(); step(); check1("halt_rd2", IMemRd, 1'b0); check16("halt_addr2", IMemAddr, 16'h0008);
    Redirect = 1'b1; RedirectPC = 16'h0020;
    step(); check1("resume_rd", IMemRd, 1'b1); check16("resume_addr", IMemAddr, 16'h0020);
    Redirect = 1'b0; Halt = 1'b0; mem_hit(16'hC001);
    step(); check16("resume_instr", DecInstruct, 16'hC011); check16("resume_pcinc", DecPCInc, 16'h0022);

    // PC wrap and asynchronous reset mid-stall
    Redirect = 1'b1; RedirectPC = 16'hFFFE; IMemDone = 1'b0;
    step(); check16("wrap_addr", IMemAddr, 16'hFFFE);
    Redirect = 1'b0; IMemDone = IMemRd; IMemData = 16'h1234;
    step(); check16("wrap_instr", DecInstruct, 16'h1234); check16("wrap_pcinc", DecPCInc, 16'h0000);
    check16("wrap_addr0", IMemAddr, 16'h0000);
    mem_hit(16'hC001);
    step(); check16("post_wrap_pcinc", DecPCInc, 16'h0002); check16("post_wrap_addr", IMemAddr, 16'h0002);
    En = 1'b0; IMemDone = 1'b0; IMemStall = 1'b1;
    step(); check1("pre_rst_valid", DecValid, 1'b1);
    #1 rst = 1'b1;
    #1;
    check1("arst_valid", DecValid, 1'b0); check16("arst_instr", DecInstruct, 16'h0800);
    check16("arst_pcinc", DecPCInc, 16'h0000); check1("arst_rd", IMemRd, 1'b0);
    check16("arst_addr", IMemAddr, 16'h0000);
    step(); rst = 1'b0; IMemStall = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      En = ($urandom_range(0, 3) >= ((c / 1000) % 3));
      if ($urandom_range(0, 2) == 0) begin
        IMemDone = 1'b1; IMemStall = 1'b0;
      end else begin
        IMemDone = 1'b0; IMemStall = 1'($urandom_range(0, 1));
      end
      IMemData   = 16'($urandom);
      Redirect   = ($urandom_range(0, 24) == 0);
      RedirectPC = ($urandom_range(0, 7) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
      Halt       = ($urandom_range(0, 49) == 0);
      step();
      if ($urandom_range(0, 599) == 0) begin
        #1 rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
